windowed_ram: RTL
=================

# windowed_ram

Parametrised, address-windowed, simple-dual-port synchronous RAM, the successor to the fixed 32 KiB data RAM on the CPU bus. Both ports take absolute bus addresses and decode them against a parametrised base/size window. Read latency is configurable, and a valid strobe accompanies read data. Same-cycle read/write collisions resolve deterministically, and out-of-window writes are trapped in a sticky error flag instead of aliasing into the array.

## Interface
- ADDR_WIDTH, 16: bus address width, both ports.
- DEPTH_LOG2, 15: log2 of word count; window size = 2^DEPTH_LOG2. Must be ≤ ADDR_WIDTH.
- WORD_SIZE, 8: data width in bits.
- BASE_ADDR, 16'h8000: window base; must be aligned to 2^DEPTH_LOG2.
- READ_LATENCY, 1: cycles from RE sample to RdValid; legal 1..4.
- BYPASS, 1: 1 = read of a word written in the same cycle returns new data; 0 = returns old data.

Ports:
- CLK  in  1  clock; all logic is rising-edge.
- RSTn  in  1  reset, synchronous and active-low.
- WrAddr  in  ADDR_WIDTH  absolute write address.
- WrData  in  WORD_SIZE  write data.
- WE  in  1  write strobe.
- RdAddr  in  ADDR_WIDTH  absolute read address.
- RE  in  1  read request.
- RdData  out  WORD_SIZE  read data; valid only while RdValid is high.
- RdValid  out  1  one-cycle pulse per accepted RE.
- RdMiss  out  1  qualifies RdValid; high = that read was out of window.
- WrErr  out  1  sticky; set by an out-of-window write.
- ErrClr  in  1  clears WrErr.

## Operation
- Window hit: (addr & ~(2^DEPTH_LOG2-1)) == BASE_ADDR. Index = addr[DEPTH_LOG2-1:0]. No subtraction is used; alignment makes masking exact.
- Write: WE=1 and hit → Mem[index] ← WrData at the edge.
- Out-of-window write: WE=1 and miss → array untouched; WrErr ← 1 at the edge.
- WrErr clears on RSTn=0 or ErrClr=1. If ErrClr and a new miss occur in the same cycle, set wins (WrErr=1).
- Read: RE=1 is sampled at an edge, and the array is read at that edge.
  - Result enters a valid/data/miss shift pipeline of READ_LATENCY stages.
  - Reads are fully pipelined: RE may be high every cycle, and each request produces exactly one RdValid, in order.
- Read miss: array not consulted; RdData = 0, RdMiss = 1 in the matching RdValid cycle.
- Collision: WE and RE in the same cycle, both hit, same index.
  - BYPASS=1 → returned data = WrData.
  - BYPASS=0 → returned data = prior Mem contents.
  - The write always completes.
- Array contents are not reset and are undefined until written.
- Reset values (RSTn=0 at an edge):
  - RdValid=0, RdMiss=0, RdData=0, WrErr=0, all pipeline valid bits cleared.
  - In-flight reads are discarded with no RdValid.
  - WE and RE are ignored during reset; no array write occurs.
- RdData holds its last value while RdValid=0.

## Timing
- RE sampled at edge N → RdValid/RdData/RdMiss registered at edge N+READ_LATENCY-1. They are visible in the cycle after that edge.
- With READ_LATENCY=1, data is visible the cycle after RE, matching the previous RAM.
- Write-to-read: a write at edge N is visible to a read sampled at edge N+1, regardless of BYPASS. Same-edge behaviour is set by BYPASS.
- WrErr rises in the cycle after the offending write, and falls the cycle after ErrClr.
- Throughput: one write and one read per cycle.
- Address decode is purely combinational on inputs and adds no latency.

## Structure
- Package ram_pkg holds:
  - a window-hit function (addr, base, log2 size);
  - the READ_LATENCY legal-range constants;
  - an elaboration check for BASE_ADDR alignment and for DEPTH_LOG2 ≤ ADDR_WIDTH.
- Sub-module ram_core: a bare simple-dual-port array (write port, registered read port, no reset), kept separate so it infers block RAM.
- windowed_ram wraps ram_core and adds decode, the collision mux, the latency pipeline and the error flag.

## Test plan
- Reset then fill: hold RSTn=0 for 2 cycles → all outputs 0. Write 0x8000..0x800F with data 0xA0+i, then read back at READ_LATENCY=1 and 3 → data 0xA0+i. RdValid asserts exactly 1 and 3 cycles after each RE, with back-to-back reads every cycle.
- Window edges: write 0x7FFF and 0x10000-equivalent misses → array unchanged and WrErr=1. Read 0x7FFF → RdValid=1, RdMiss=1, RdData=0. Write/read 0xFFFF → hit, index 0x7FFF.
- Collision: Mem[0x8005]=0x11; same cycle WE 0x8005←0x22 and RE 0x8005. BYPASS=1 returns 0x22; BYPASS=0 returns 0x11. A following read returns 0x22 in both cases.
- Error flag: miss write, then ErrClr → WrErr 1→0. Miss write together with ErrClr → WrErr stays 1.
- Reset mid-read: READ_LATENCY=3, issue RE for 3 cycles, then drop RSTn for 1 cycle → no RdValid emerges. RdData=0, and a subsequent read returns correct data.
- Non-default parameters: WORD_SIZE=16, DEPTH_LOG2=8, BASE_ADDR=0x0100 → write 0x01FF←0xBEEF reads back 0xBEEF. 0x0200 is a miss.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared definitions for windowed_ram: window decode, legal read-latency range,
// parameter sanity check and the read-data source selector.
package ram_pkg;

  localparam int READ_LATENCY_MIN = 1;
  localparam int READ_LATENCY_MAX = 4;

  typedef enum logic [1:0] {
    SRC_ZERO = 2'd0,
    SRC_MEM  = 2'd1,
    SRC_BYP  = 2'd2
  } rd_src_e;

  // Base is aligned to the window size, so masking off the index bits is an exact compare.
  function automatic logic win_hit(input logic [63:0] addr, input logic [63:0] base,
                                   input int log2sz);
    logic [63:0] mask;
    mask = ~((64'd1 << log2sz) - 64'd1);
    return (addr & mask) == base;
  endfunction

  function automatic logic cfg_ok(input int aw, input int dl, input logic [63:0] base,
                                  input int lat);
    logic [63:0] low;
    low = (64'd1 << dl) - 64'd1;
    return (dl >= 1) && (dl <= aw) && ((base & low) == 64'd0) &&
           (lat >= READ_LATENCY_MIN) && (lat <= READ_LATENCY_MAX);
  endfunction

endpackage

// File: rtl/windowed_ram_if.sv
// CPU-side bus of windowed_ram: one write port, one read port, error flag control.
interface windowed_ram_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int WORD_SIZE  = 8
);
  logic [ADDR_WIDTH-1:0] WrAddr;
  logic [WORD_SIZE-1:0]  WrData;
  logic                  WE;
  logic [ADDR_WIDTH-1:0] RdAddr;
  logic                  RE;
  logic [WORD_SIZE-1:0]  RdData;
  logic                  RdValid;
  logic                  RdMiss;
  logic                  WrErr;
  logic                  ErrClr;

  modport master (
    output WrAddr, WrData, WE, RdAddr, RE, ErrClr,
    input  RdData, RdValid, RdMiss, WrErr
  );

  modport slave (
    input  WrAddr, WrData, WE, RdAddr, RE, ErrClr,
    output RdData, RdValid, RdMiss, WrErr
  );
endinterface

// File: rtl/ram_core.sv
// Bare simple-dual-port array with a registered read port and no reset, shaped for
// block-RAM inference. A same-address read and write return the old contents.
module ram_core #(
  parameter int DEPTH_LOG2 = 15,
  parameter int WORD_SIZE  = 8
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [DEPTH_LOG2-1:0] waddr_i,
  input  logic [WORD_SIZE-1:0]  wdata_i,
  input  logic                  re_i,
  input  logic [DEPTH_LOG2-1:0] raddr_i,
  output logic [WORD_SIZE-1:0]  rdata_o
);
  logic [WORD_SIZE-1:0] mem_q [2**DEPTH_LOG2];
  logic [WORD_SIZE-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/windowed_ram.sv
// Address-windowed RAM: decodes absolute bus addresses against BASE_ADDR, resolves
// same-cycle collisions, delays reads by READ_LATENCY and traps stray writes in WrErr.
module windowed_ram
  import ram_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = 16,
  parameter int                    DEPTH_LOG2   = 15,
  parameter int                    WORD_SIZE    = 8,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = 16'h8000,
  parameter int                    READ_LATENCY = 1,
  parameter int                    BYPASS       = 1
) (
  input logic           CLK,
  input logic           RSTn,
  windowed_ram_if.slave bus
);
  localparam int L = READ_LATENCY;

  if (!cfg_ok(ADDR_WIDTH, DEPTH_LOG2, 64'(BASE_ADDR), READ_LATENCY)) begin : g_bad_cfg
    $error("windowed_ram: unaligned BASE_ADDR, DEPTH_LOG2 > ADDR_WIDTH or READ_LATENCY out of range");
  end

  logic                  wr_hit, rd_hit, wr_en, rd_en, collide;
  logic [DEPTH_LOG2-1:0] wr_idx, rd_idx;
  logic [WORD_SIZE-1:0]  core_rdata, s0_data;
  logic [WORD_SIZE-1:0]  byp_q, byp_d;
  rd_src_e               src_q, src_d;
  logic [L-1:0]          vld_q, vld_d, miss_q, miss_d;
  logic                  wrerr_q, wrerr_d;

  assign wr_hit  = win_hit(64'(bus.WrAddr), 64'(BASE_ADDR), DEPTH_LOG2);
  assign rd_hit  = win_hit(64'(bus.RdAddr), 64'(BASE_ADDR), DEPTH_LOG2);
  assign wr_idx  = bus.WrAddr[DEPTH_LOG2-1:0];
  assign rd_idx  = bus.RdAddr[DEPTH_LOG2-1:0];
  assign wr_en   = RSTn && bus.WE && wr_hit;
  assign rd_en   = RSTn && bus.RE && rd_hit;
  assign collide = wr_en && rd_en && (wr_idx == rd_idx) && (BYPASS != 0);

  ram_core #(
    .DEPTH_LOG2(DEPTH_LOG2),
    .WORD_SIZE (WORD_SIZE)
  ) u_core (
    .clk_i  (CLK),
    .we_i   (wr_en),
    .waddr_i(wr_idx),
    .wdata_i(bus.WrData),
    .re_i   (rd_en),
    .raddr_i(rd_idx),
    .rdata_o(core_rdata)
  );

  always_comb begin
    src_d     = src_q;
    byp_d     = byp_q;
    vld_d[0]  = bus.RE;
    miss_d[0] = bus.RE && !rd_hit;
    for (int k = 1; k < L; k++) begin
      vld_d[k]  = vld_q[k-1];
      miss_d[k] = miss_q[k-1];
    end
    // src only moves on an accepted read, so stage-0 data holds between reads.
    if (bus.RE) begin
      if (!rd_hit) begin
        src_d = SRC_ZERO;
      end else if (collide) begin
        src_d = SRC_BYP;
        byp_d = bus.WrData;
      end else begin
        src_d = SRC_MEM;
      end
    end
    wrerr_d = wrerr_q;
    if (bus.ErrClr) wrerr_d = 1'b0;
    if (bus.WE && !wr_hit) wrerr_d = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      src_q   <= SRC_ZERO;
      vld_q   <= '0;
      miss_q  <= '0;
      wrerr_q <= 1'b0;
    end else begin
      src_q   <= src_d;
      vld_q   <= vld_d;
      miss_q  <= miss_d;
      wrerr_q <= wrerr_d;
    end
  end

  always_ff @(posedge CLK) byp_q <= byp_d;

  always_comb begin
    unique case (src_q)
      SRC_MEM: s0_data = core_rdata;
      SRC_BYP: s0_data = byp_q;
      default: s0_data = '0;
    endcase
  end

  // Stage 0 is the array's own read register; extra stages only load on a valid word.
  if (L == 1) begin : g_direct
    assign bus.RdData = s0_data;
  end else begin : g_pipe
    logic [WORD_SIZE-1:0] dat_q [L-1];
    logic [WORD_SIZE-1:0] dat_d [L-1];

    always_comb begin
      for (int k = 0; k < L - 1; k++) dat_d[k] = dat_q[k];
      if (vld_q[0]) dat_d[0] = s0_data;
      for (int k = 1; k < L - 1; k++) begin
        if (vld_q[k]) dat_d[k] = dat_q[k-1];
      end
    end

    always_ff @(posedge CLK) begin
      if (!RSTn) begin
        for (int k = 0; k < L - 1; k++) dat_q[k] <= '0;
      end else begin
        for (int k = 0; k < L - 1; k++) dat_q[k] <= dat_d[k];
      end
    end

    assign bus.RdData = dat_q[L-2];
  end

  assign bus.RdValid = vld_q[L-1];
  assign bus.RdMiss  = miss_q[L-1];
  assign bus.WrErr   = wrerr_q;
endmodule
